fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 4x8 processor buffer.
- Generalised word width and depth.
- Independent read and write strobes, accepted in the same cycle.
- Registered read data with a valid strobe; no tri-state output.
- Adds a programmable almost-full interrupt, an occupancy count, and sticky overflow/underflow error flags.
- Sits between the processor bus and a peripheral consumer, single clock domain.

Parameters:
- WIDTH, 8: data word width in bits, 1 or more.
- DEPTH, 4: number of storage entries, 2 or more. Need not be a power of two.
- AF_THRESH, DEPTH: `intr` asserts when `count` >= AF_THRESH. Legal range 1..DEPTH.
- CW, $clog2(DEPTH+1): width of `count`. Derived localparam, not overridable.

Ports:
- pclk  in  1  clock; all state updates on rising edge.
- clear  in  1  synchronous reset, active-high; has priority over all other inputs.
- en  in  1  block enable; when low, wr_en/rd_en are ignored and no flags change.
- wr_en  in  1  write request.
- wdata  in  WIDTH  write word, sampled at the rising edge with wr_en.
- rd_en  in  1  read request.
- err_clr  in  1  clears the sticky ovf/udf flags.
- rdata  out  WIDTH  read word, registered.
- rvalid  out  1  rdata carries a newly popped word this cycle.
- nempty  out  1  count != 0.
- full  out  1  count == DEPTH.
- count  out  CW  current occupancy.
- intr  out  1  almost-full interrupt.
- ovf  out  1  sticky: write rejected because the FIFO was full.
- udf  out  1  sticky: read rejected because the FIFO was empty.

Behaviour:
- Storage:
  - DEPTH x WIDTH register array.
  - Write pointer wp and read pointer rp, each 0..DEPTH-1.
  - Each pointer wraps from DEPTH-1 to 0, explicitly, not by bit overflow.
  - Separate `count` register; full and empty are derived from `count` only.
- Reset (clear=1 at an edge):
  - wp, rp, count, rdata, rvalid, ovf and udf all go to 0.
  - Array contents are don't-care.
  - Takes effect mid-operation regardless of en, wr_en or rd_en.
  - Outputs after reset: nempty=0, full=0, intr=0.
- Acceptance, evaluated on pre-edge state, only when en=1:
  - wr_ok = wr_en & ~full.
  - rd_ok = rd_en & nempty.
- Write when wr_ok: mem[wp] <= wdata; wp advances.
- Read when rd_ok:
  - rdata <= mem[rp]; rp advances.
  - rvalid=1 in the following cycle only: one-cycle read latency.
  - rvalid=0 in all other cycles; rdata holds its last value.
- Count update:
  - +1 for wr_ok only, -1 for rd_ok only.
  - Unchanged if both or neither.
- Simultaneous events:
  - Full with wr_en and rd_en: the read is accepted, the write is rejected (no pass-through). ovf sets; count goes DEPTH-1.
  - Empty with wr_en and rd_en: the write is accepted, the read is rejected (no bypass). udf sets; count goes to 1.
  - Otherwise both are accepted together; count unchanged, pointers both advance.
- Errors:
  - ovf sets on en & wr_en & full.
  - udf sets on en & rd_en & ~nempty.
  - Both flags hold until err_clr=1 or clear=1.
  - If err_clr and a new error occur in the same cycle, set wins.
  - Rejected operations never modify pointers, count or the array.
- intr:
  - Combinational from the count register: (count >= AF_THRESH).
  - Not gated by rw or en, unlike the previous block.
- en=0: state holds, rvalid goes 0, flags hold; err_clr is still honoured.
- No combinational path from any input to any output, except the count-derived flags, which come from registers.

Test Plan:
- clear=1 for 2 cycles with wr_en=rd_en=1 -> count=0, nempty=0, rvalid=0, ovf=udf=0; then clear=0.
- DEPTH=4, AF_THRESH=3: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4; intr rises after the third write; full=1 after the fourth. A fifth write of 0x55 -> ovf=1, count stays 4.
- From full, read 4 times -> rdata 0x11, 0x22, 0x33, 0x44, each with rvalid=1 one cycle after rd_en; count falls to 0. A fifth read -> udf=1, rvalid=0, rdata holds 0x44.
- Hold count=2 with continuous simultaneous wr/rd for 10 cycles (wdata 0xA0..0xA9) -> count stays 2; data order preserved; wp and rp wrap past 3 with no corruption.
- Edge cases:
  - Empty with wr_en=rd_en=1 and wdata=0x5A -> count=1, udf=1, rvalid=0 next cycle.
  - Full with both strobes -> count=3, ovf=1, head word is returned.
  - err_clr then clears both flags.
- Mid-stream clear at count=3 -> next cycle count=0, nempty=0. A following write then read returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full interrupt and sticky error flags.
// Latency: a written word is readable the next cycle; rdata/rvalid appear one cycle after an accepted rd_en.
// Backpressure: writes are rejected while full (sets ovf); reads are rejected while empty (sets udf).
module fifo_sync_param #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 4,
    parameter  int AF_THRESH = DEPTH,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             pclk,
    input  logic             clear,
    input  logic             en,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             nempty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             intr,
    output logic             ovf,
    output logic             udf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_set;
    logic             udf_set;

    // Explicit wrap so non-power-of-two depths step DEPTH-1 -> 0.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign nempty  = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign intr    = (count >= CW'(AF_THRESH));

    assign wr_ok   = en & wr_en & ~full;
    assign rd_ok   = en & rd_en & nempty;
    assign ovf_set = en & wr_en & full;
    assign udf_set = en & rd_en & ~nempty;

    always_ff @(posedge pclk) begin
        if (wr_ok && !clear) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (clear) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (wr_ok) begin
                wp <= next_ptr(wp);
            end
            if (rd_ok) begin
                rdata <= mem[rp];
                rp    <= next_ptr(rp);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            ovf <= ovf_set | (ovf & ~err_clr);
            udf <= udf_set | (udf & ~err_clr);
        end
    end

endmodule
